// File: rtl/mem_refill_arbiter.sv
// mem_refill_arbiter: round-robin sharing of one memory word port between I- and D-cache line bursts
module mem_refill_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_WORDS = 4,
    localparam int IDX_W = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic [IDX_W-1:0]  i_ridx,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    output logic [IDX_W-1:0]  d_widx,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [IDX_W-1:0]  d_ridx,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;
    state_t state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic last_q, last_d, we_q, we_d, pick_d;
    logic busy_i, busy_d, done;
    // last_q = 1 when D held the port most recently, so a contest then goes to I
    assign pick_d = d_req & (~i_req | ~last_q);
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        base_d = base_q;
        last_d = last_q;
        we_d = we_q;
        case (state_q)
            IDLE: if (i_req | d_req) begin
                state_d = pick_d ? BUSY_D : BUSY_I;
                cnt_d = '0;
                base_d = (pick_d ? d_addr : i_addr) & ~ADDR_W'(4 * LINE_WORDS - 1);
                last_d = pick_d;
                we_d = pick_d & d_we;
            end
            BUSY_I, BUSY_D: if (mem_ready) begin
                cnt_d = cnt_q + 1'b1;
                state_d = (cnt_q == IDX_W'(LINE_WORDS - 1)) ? DONE : state_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q <= '0;
            base_q <= '0;
            last_q <= 1'b0;
            we_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            base_q <= base_d;
            last_q <= last_d;
            we_q <= we_d;
        end
    end
    assign busy_i = state_q == BUSY_I;
    assign busy_d = state_q == BUSY_D;
    assign done = state_q == DONE;
    assign i_gnt = busy_i;
    assign i_rvalid = busy_i & mem_ready;
    assign i_rdata = i_rvalid ? mem_rdata : '0;
    assign i_ridx = i_rvalid ? cnt_q : '0;
    assign i_done = done & ~last_q;
    assign d_gnt = busy_d;
    assign d_rvalid = busy_d & mem_ready & ~we_q;
    assign d_rdata = d_rvalid ? mem_rdata : '0;
    assign d_ridx = d_rvalid ? cnt_q : '0;
    assign d_widx = busy_d ? cnt_q : '0;
    assign d_done = done & last_q;
    assign mem_req = busy_i | busy_d;
    assign mem_we = busy_d & we_q;
    assign mem_addr = mem_req ? (base_q | (ADDR_W'(cnt_q) << 2)) : '0;
    assign mem_wdata = busy_d ? d_wdata : '0;
endmodule

// File: tb/tb_mem_refill_arbiter.sv
// tb_mem_refill_arbiter: scoreboard bench; expected memory words queued at request time, popped on each handshake
module tb_mem_refill_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata, mem_rdata, mem_addr, mem_wdata, i_rdata, d_rdata;
    logic [31:0] wbase = '0;
    logic [1:0] i_ridx, d_ridx, d_widx;
    logic i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done, mem_req, mem_we, mem_ready;
    int stall = 0, wcnt = 0, errors = 0, checks = 0;

    typedef struct {logic side; logic we; logic [31:0] addr; logic [31:0] wdata; logic [1:0] idx;} exp_t;
    exp_t sb[$];

    mem_refill_arbiter dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .i_ridx(i_ridx), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_widx(d_widx), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_ridx(d_ridx), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;
    assign d_wdata = wbase + 32'(d_widx);
    assign mem_rdata = mem_addr ^ 32'h5A5A_0000;
    assign mem_ready = wcnt >= stall;
    always @(posedge clk) wcnt <= (!mem_req || mem_ready) ? 0 : wcnt + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mem_req && mem_ready) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_word addr=%h expected none", mem_addr);
            end else begin
                e = sb.pop_front();
                checks++;
                if (mem_addr !== e.addr || mem_we !== e.we || {d_gnt, i_gnt} !== {e.side, !e.side}) begin
                    errors++;
                    $display("FAIL word_ctrl addr=%h we=%b gnt_di=%b%b expected addr=%h we=%b side=%b",
                             mem_addr, mem_we, d_gnt, i_gnt, e.addr, e.we, e.side);
                end
                checks++;
                if (e.we && (mem_wdata !== e.wdata || d_widx !== e.idx || {i_rvalid, d_rvalid} !== 2'b00)) begin
                    errors++;
                    $display("FAIL word_write wdata=%h widx=%0d rvalid=%b%b expected wdata=%h widx=%0d rvalid=00",
                             mem_wdata, d_widx, i_rvalid, d_rvalid, e.wdata, e.idx);
                end
                if (!e.we && ({i_rvalid, d_rvalid} !== {!e.side, e.side} ||
                              (e.side ? d_rdata : i_rdata) !== (e.addr ^ 32'h5A5A_0000) ||
                              (e.side ? d_ridx : i_ridx) !== e.idx)) begin
                    errors++;
                    $display("FAIL word_read rvalid_id=%b%b rdata_i=%h rdata_d=%h ridx_i=%0d ridx_d=%0d expected side=%b rdata=%h ridx=%0d",
                             i_rvalid, d_rvalid, i_rdata, d_rdata, i_ridx, d_ridx, e.side, e.addr ^ 32'h5A5A_0000, e.idx);
                end
            end
        end
    end

    task automatic push_burst(input logic side, input logic we, input logic [31:0] base, input logic [31:0] wb);
        for (int k = 0; k < 4; k++) sb.push_back('{side, we, base + 32'(4 * k), wb + 32'(k), 2'(k)});
    endtask

    task automatic wait_done(input logic side, output int n);
        n = -1;
        for (int k = 1; k <= 200 && n < 0; k++) begin
            @(negedge clk);
            if (side ? d_done : i_done) begin
                n = k;
                if (side) d_req = 1'b0; else i_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done, mem_req, mem_we} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl got=%b expected=00000000",
                     {i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done, mem_req, mem_we});
        end
        checks++;
        if ({i_rdata, i_ridx, d_rdata, d_ridx, d_widx, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_data mem_addr=%h mem_wdata=%h expected 0", mem_addr, mem_wdata);
        end
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
    endtask

    task automatic test_i_refill;
        int n;
        @(posedge clk); #1;
        i_addr = 32'h1234;
        push_burst(1'b0, 1'b0, 32'h1230, 32'h0);
        i_req = 1'b1;
        wait_done(1'b0, n);
        checks++;
        if (n !== 6) begin errors++; $display("FAIL i_refill_latency got=%0d expected=6", n); end
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL i_refill_words left=%0d expected=0", sb.size()); end
    endtask

    task automatic test_d_writeback;
        int n;
        @(posedge clk); #1;
        d_addr = 32'h80; d_we = 1'b1; wbase = 32'hA0;
        push_burst(1'b1, 1'b1, 32'h80, 32'hA0);
        d_req = 1'b1;
        wait_done(1'b1, n);
        checks++;
        if (n !== 6) begin errors++; $display("FAIL d_wb_latency got=%0d expected=6", n); end
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL d_wb_words left=%0d expected=0", sb.size()); end
        d_we = 1'b0;
    endtask

    task automatic test_contest;
        int n;
        @(posedge clk); #1 resetn = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        for (int r = 0; r < 2; r++) begin
            d_addr = 32'h200 + 32'(r * 32'h40); i_addr = 32'h300 + 32'(r * 32'h40);
            push_burst(1'b1, 1'b0, d_addr, 32'h0);
            push_burst(1'b0, 1'b0, i_addr, 32'h0);
            d_req = 1'b1; i_req = 1'b1;
            wait_done(1'b1, n);
            checks++;
            if (n !== 6) begin errors++; $display("FAIL contest_d_first round=%0d got=%0d expected=6", r, n); end
            wait_done(1'b0, n);
            checks++;
            if (n !== 6) begin errors++; $display("FAIL contest_i_second round=%0d got=%0d expected=6", r, n); end
        end
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL contest_words left=%0d expected=0", sb.size()); end
    endtask

    task automatic test_stall;
        logic [31:0] pa, pw;
        logic pstall;
        int ndone, dcyc;
        @(posedge clk); #1;
        d_addr = 32'h104; d_we = 1'b1; wbase = 32'h50; stall = 3;
        push_burst(1'b1, 1'b1, 32'h100, 32'h50);
        d_req = 1'b1;
        pstall = 1'b0; pa = '0; pw = '0; ndone = 0; dcyc = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (pstall) begin
                checks++;
                if (mem_addr !== pa || mem_wdata !== pw) begin
                    errors++;
                    $display("FAIL stall_stable cycle=%0d addr=%h wdata=%h expected addr=%h wdata=%h", k, mem_addr, mem_wdata, pa, pw);
                end
            end
            pstall = mem_req && !mem_ready; pa = mem_addr; pw = mem_wdata;
            if (d_done) begin ndone++; dcyc = k; d_req = 1'b0; end
        end
        stall = 0; d_we = 1'b0;
        checks++;
        if (ndone !== 1 || dcyc !== 18) begin
            errors++;
            $display("FAIL stall_done count=%0d cycle=%0d expected count=1 cycle=18", ndone, dcyc);
        end
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL stall_words left=%0d expected=0", sb.size()); end
    endtask

    task automatic test_reset_mid;
        int n;
        @(posedge clk); #1;
        i_addr = 32'h500;
        sb.push_back('{1'b0, 1'b0, 32'h500, 32'h0, 2'd0});
        sb.push_back('{1'b0, 1'b0, 32'h504, 32'h0, 2'd1});
        i_req = 1'b1;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done, mem_req, mem_we} !== 8'h00 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_outputs ctrl=%b addr=%h expected all 0",
                     {i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done, mem_req, mem_we}, mem_addr);
        end
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL reset_mid_words left=%0d expected=0", sb.size()); end
        @(posedge clk); #1 resetn = 1'b1;
        push_burst(1'b0, 1'b0, 32'h500, 32'h0);
        wait_done(1'b0, n);
        checks++;
        if (n !== 6) begin errors++; $display("FAIL reset_mid_restart got=%0d expected=6", n); end
    endtask

    task automatic test_d_during_i;
        int n;
        @(posedge clk); #1;
        i_addr = 32'h600;
        push_burst(1'b0, 1'b0, 32'h600, 32'h0);
        push_burst(1'b1, 1'b0, 32'h700, 32'h0);
        i_req = 1'b1;
        repeat (2) @(posedge clk);
        #1 d_req = 1'b1; d_we = 1'b0; d_addr = 32'h708;
        wait_done(1'b0, n);
        checks++;
        if (n !== 4 || mem_req !== 1'b0 || d_gnt !== 1'b0) begin
            errors++;
            $display("FAIL d_wait_done cycle=%0d mem_req=%b d_gnt=%b expected cycle=4 mem_req=0 d_gnt=0", n, mem_req, d_gnt);
        end
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || d_gnt !== 1'b0) begin
            errors++;
            $display("FAIL d_wait_idle mem_req=%b d_gnt=%b expected 0 0", mem_req, d_gnt);
        end
        wait_done(1'b1, n);
        checks++;
        if (n !== 5) begin errors++; $display("FAIL d_after_i got=%0d expected=5", n); end
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL d_after_i_words left=%0d expected=0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_i_refill();
        test_d_writeback();
        test_contest();
        test_stall();
        test_reset_mid();
        test_d_during_i();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "timeout");
    end
endmodule
